// File: rtl/zbt_disp_reader.sv
// Display-side ZBT reader: prefetches pixel-pair words ahead of the VGA counters and
// unpacks them so pix_out lines up with the current hcount despite the ZBT read latency.
module zbt_disp_reader #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 1344,
  parameter int V_TOTAL  = 806,
  parameter int ZBT_LAT  = 2,
  parameter int PREFETCH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic [35:0] read_data,
  output logic [18:0] read_addr,
  output logic [17:0] pix_out,
  output logic        pix_valid
);

  localparam int WORDS = H_ACTIVE / 2;

  logic [11:0]        th_sum;
  logic [10:0]        tv_inc;
  logic [10:0]        th;
  logic [9:0]         tv;
  logic               in_range;
  logic               tgt_valid;
  logic [18:0]        addr_d,  read_addr_q;
  logic [17:0]        pix_d,   pix_q;
  logic               pix_valid_d, pix_valid_q;
  logic [ZBT_LAT:0]   tag_vld_q, tag_odd_q;

  // Target pixel PREFETCH ahead, wrapping into the next line and the next frame.
  always_comb begin
    th_sum   = {1'b0, hcount} + 12'(PREFETCH);
    tv_inc   = {1'b0, vcount} + 11'd1;
    th       = th_sum[10:0];
    tv       = vcount;
    if (th_sum >= 12'(H_TOTAL)) begin
      th = 11'(th_sum - 12'(H_TOTAL));
      tv = (tv_inc == 11'(V_TOTAL)) ? 10'd0 : tv_inc[9:0];
    end
    in_range  = (hcount < 11'(H_TOTAL)) && (vcount < 10'(V_TOTAL));
    tgt_valid = in_range && (th < 11'(H_ACTIVE)) && (tv < 10'(V_ACTIVE));
    addr_d    = tgt_valid ? (19'(tv) * 19'(WORDS) + 19'(th[10:1])) : read_addr_q;
  end

  // Tag bit 0 travels with read_addr; bit ZBT_LAT meets the matching read_data.
  always_comb begin
    pix_d       = '0;
    pix_valid_d = 1'b0;
    if (tag_vld_q[ZBT_LAT]) begin
      pix_d       = tag_odd_q[ZBT_LAT] ? read_data[17:0] : read_data[35:18];
      pix_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      read_addr_q <= '0;
      tag_vld_q   <= '0;
      tag_odd_q   <= '0;
      pix_q       <= '0;
      pix_valid_q <= 1'b0;
    end else begin
      read_addr_q <= addr_d;
      tag_vld_q   <= {tag_vld_q[ZBT_LAT-1:0], tgt_valid};
      tag_odd_q   <= {tag_odd_q[ZBT_LAT-1:0], th[0]};
      pix_q       <= pix_d;
      pix_valid_q <= pix_valid_d;
    end
  end

  assign read_addr = read_addr_q;
  assign pix_out   = pix_q;
  assign pix_valid = pix_valid_q;

endmodule

// File: tb/tb_zbt_disp_reader.sv
// Bench for zbt_disp_reader: directed raster segments plus random ones, checked against
// a raster-position model of which pixel and which ZBT word should appear each cycle.
module tb_zbt_disp_reader;

  localparam int HT  = 1344;
  localparam int VT  = 806;
  localparam int TOT = HT * VT;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [10:0] hcount = '0;
  logic [9:0]  vcount = '0;
  logic [35:0] read_data;
  logic [18:0] read_addr;
  logic [17:0] pix_out;
  logic        pix_valid;

  int vectors = 0;
  int miscompares = 0;

  int prev_h = 0, prev_v = 0;
  bit prev_r = 1'b1;
  int run_len = 0, since_rst = 0;
  logic [18:0] exp_addr = '0;

  zbt_disp_reader dut (
    .clk       (clk),
    .reset     (reset),
    .hcount    (hcount),
    .vcount    (vcount),
    .read_data (read_data),
    .read_addr (read_addr),
    .pix_out   (pix_out),
    .pix_valid (pix_valid)
  );

  always #5 clk = ~clk;

  // Memory: word n = {n[17:0], ~n[17:0]}, two clocks after the address is presented.
  logic [18:0] mem_p1 = '0, mem_p2 = '0;
  always @(posedge clk) begin
    mem_p1 <= read_addr;
    mem_p2 <= mem_p1;
  end
  assign read_data = {mem_p2[17:0], ~mem_p2[17:0]};

  function automatic int lin(input int h, input int v);
    return v * HT + h;
  endfunction

  // Raster position four pixels ahead; returns whether it is an image pixel.
  function automatic bit target(input int h, input int v, output int addr);
    int p, th, tv;
    addr = 0;
    if (h >= HT || v >= VT) return 1'b0;
    p  = (lin(h, v) + 4) % TOT;
    th = p % HT;
    tv = p / HT;
    addr = tv * 320 + th / 2;
    return (th < 640) && (tv < 480);
  endfunction

  function automatic logic [17:0] pixel(input int h, input int v);
    int n;
    logic [17:0] nn;
    n  = v * 320 + h / 2;
    nn = n[17:0];
    return (h % 2 == 1) ? ~nn : nn;
  endfunction

  task automatic chk(input string tag, input int h, input int v,
                     input logic [18:0] obs, input logic [18:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s at v=%0d h=%0d observed=%0h expected=%0h", tag, v, h, obs, expv);
    end
  endtask

  task automatic step(input int h, input int v, input bit r);
    int a;
    bit ev;
    @(negedge clk);
    if (prev_r) exp_addr = '0;
    else if (target(prev_h, prev_v, a)) exp_addr = 19'(a);
    if (prev_r) begin
      run_len   = 1;
      since_rst = 1;
    end else begin
      since_rst++;
      if (prev_h < HT && prev_v < VT && h < HT && v < VT &&
          lin(h, v) == (lin(prev_h, prev_v) + 1) % TOT)
        run_len++;
      else
        run_len = 1;
    end
    hcount = 11'(h);
    vcount = 10'(v);
    reset  = r;
    chk("read_addr", h, v, read_addr, exp_addr);
    if (run_len >= 5) begin
      ev = (h < 640) && (v < 480);
      chk("pix_valid", h, v, 19'(pix_valid), 19'(ev));
      chk("pix_out", h, v, 19'(pix_out), ev ? 19'(pixel(h, v)) : 19'd0);
    end else if (since_rst <= 4) begin
      chk("pix_valid_flush", h, v, 19'(pix_valid), 19'd0);
      chk("pix_out_flush", h, v, 19'(pix_out), 19'd0);
    end
    $display("step v=%0d h=%0d rst=%0d addr=%0d pix=%05h valid=%0d",
             v, h, r, read_addr, pix_out, pix_valid);
    prev_h = h;
    prev_v = v;
    prev_r = r;
  endtask

  task automatic run(input int h0, input int v0, input int n);
    int p;
    p = lin(h0, v0);
    for (int i = 0; i < n; i++) begin
      step(p % HT, p / HT, 1'b0);
      p = (p + 1) % TOT;
    end
  endtask

  initial begin
    // Reset held with sweeping counts.
    for (int i = 0; i < 4; i++) step(i * 37, i, 1'b1);
    // Start of frame.
    run(0, 0, 12);
    // Line wrap, frame wrap, right edge of the image.
    run(1336, 5, 16);
    run(1336, 805, 16);
    run(630, 10, 16);
    // Single-cycle reset in the middle of a line.
    run(290, 100, 10);
    step(300, 100, 1'b1);
    run(301, 100, 10);
    // Random raster segments.
    for (int s = 0; s < 10; s++)
      run(int'($urandom_range(0, HT - 1)), int'($urandom_range(0, VT - 1)),
          int'($urandom_range(6, 20)));
    // Out-of-range counters, then recovery.
    for (int s = 0; s < 10; s++)
      step(int'($urandom_range(HT, 2047)), int'($urandom_range(0, 1023)), 1'b0);
    for (int s = 0; s < 5; s++)
      step(int'($urandom_range(0, 639)), int'($urandom_range(VT, 1023)), 1'b0);
    run(int'($urandom_range(0, 600)), int'($urandom_range(0, 479)), 12);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
